// File: rtl/w4823_pkg.sv
// Shared types and constants for the W4823 coefficient loader.
package w4823_pkg;

  localparam int COEF_W  = 17;
  localparam int CADDR_W = 6;
  localparam int CNT_W   = 7;                 // holds 1..64
  localparam int MAX_N   = 64;
  localparam logic [7:0] HDR_DEF = 8'hA5;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CNT,
    S_ADR,
    S_B0,
    S_B1,
    S_B2,
    S_LOAD,
    S_GAP,
    S_CSUM
  } state_e;

  typedef enum logic [2:0] {
    ERR_NONE   = 3'd0,
    ERR_BADCNT = 3'd1,
    ERR_PAD    = 3'd2,
    ERR_CSUM   = 3'd3,
    ERR_TMO    = 3'd4
  } err_e;

  // Coefficient count must be in 1..64.
  function automatic logic cnt_ok(input logic [7:0] n);
    return (n != 8'd0) && (n <= 8'(MAX_N));
  endfunction

endpackage

// File: rtl/w4823_byte_tmo.sv
// Loadable down-counter that flags expiry of the inter-byte idle budget.
module w4823_byte_tmo #(
  parameter int W = 11
) (
  input  logic         clk1,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;

  // Reload on demand, otherwise count down and park at zero.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/w4823_coef_loader.sv
// Parses framed coefficient packets from a host byte stream and drives the
// FIR coefficient RAM write port one coefficient per cload pulse.
module w4823_coef_loader
  import w4823_pkg::*;
#(
  parameter int         CLOAD_GAP = 2,
  parameter int         TIMEOUT   = 1024,
  parameter logic [7:0] HDR       = HDR_DEF
) (
  input  logic               clk1,
  input  logic               rst_n,
  input  logic [7:0]         bin,
  input  logic               bin_valid,
  output logic               bin_ready,
  output logic [COEF_W-1:0]  cin,
  output logic [CADDR_W-1:0] caddr,
  output logic               cload,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [2:0]         err_code
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_e               state_q, state_d;
  logic                 bin_ready_q, busy_q, cload_q, done_q, err_q;
  err_e                 err_code_q;
  logic [COEF_W-1:0]    cin_q;
  logic [CADDR_W-1:0]   caddr_q, addr_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [3:0]           gap_q;
  logic [15:0]          coef_q;
  logic [7:0]           xor_q;

  logic hs, counting, tmo_exp, tmo_hit;

  assign hs       = bin_valid && bin_ready_q;
  // The idle budget only runs while waiting on the host inside a frame.
  assign counting = (state_q != S_IDLE) && (state_q != S_LOAD) && (state_q != S_GAP);
  assign tmo_hit  = counting && !hs && tmo_exp;

  w4823_byte_tmo #(.W(TW)) u_tmo (
    .clk1       (clk1),
    .rst_n      (rst_n),
    .load_i     (hs || !counting),
    .load_val_i (TW'(TIMEOUT - 1)),
    .en_i       (counting && !hs),
    .expired_o  (tmo_exp)
  );

  // Next-state selection; any abort lands back in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (hs && (bin == HDR)) state_d = S_CNT;
      S_CNT:  if (hs) state_d = cnt_ok(bin) ? S_ADR : S_IDLE;
      S_ADR:  if (hs) state_d = S_B0;
      S_B0:   if (hs) state_d = S_B1;
      S_B1:   if (hs) state_d = S_B2;
      S_B2:   if (hs) state_d = (bin[7:1] != 7'd0) ? S_IDLE : S_LOAD;
      // cnt_q is decremented on leaving LOAD, so test against 1 here.
      S_LOAD: begin
        if (CLOAD_GAP != 0)     state_d = S_GAP;
        else if (cnt_q > 7'd1)  state_d = S_B0;
        else                    state_d = S_CSUM;
      end
      S_GAP:  if (gap_q == 4'd0) state_d = (cnt_q != '0) ? S_B0 : S_CSUM;
      S_CSUM: if (hs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (tmo_hit) state_d = S_IDLE;
  end

  // State register, datapath and registered outputs.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bin_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      cload_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      cin_q       <= '0;
      caddr_q     <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
      gap_q       <= '0;
      coef_q      <= '0;
      xor_q       <= '0;
    end else begin
      state_q     <= state_d;
      bin_ready_q <= (state_d != S_LOAD) && (state_d != S_GAP);
      busy_q      <= (state_d != S_IDLE);
      cload_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      if (tmo_hit) begin
        err_q      <= 1'b1;
        err_code_q <= ERR_TMO;
      end else begin
        case (state_q)
          S_IDLE: if (hs && (bin == HDR)) xor_q <= '0;
          S_CNT: begin
            if (hs) begin
              if (!cnt_ok(bin)) begin
                err_q      <= 1'b1;
                err_code_q <= ERR_BADCNT;
              end else begin
                cnt_q <= bin[CNT_W-1:0];
              end
            end
          end
          S_ADR: if (hs) addr_q <= bin[CADDR_W-1:0];
          S_B0: begin
            if (hs) begin
              coef_q[7:0] <= bin;
              xor_q       <= xor_q ^ bin;
            end
          end
          S_B1: begin
            if (hs) begin
              coef_q[15:8] <= bin;
              xor_q        <= xor_q ^ bin;
            end
          end
          S_B2: begin
            if (hs) begin
              xor_q <= xor_q ^ bin;
              if (bin[7:1] != 7'd0) begin
                err_q      <= 1'b1;
                err_code_q <= ERR_PAD;
              end else begin
                cin_q   <= {bin[0], coef_q};
                caddr_q <= addr_q;
                cload_q <= 1'b1;
              end
            end
          end
          S_LOAD: begin
            addr_q <= addr_q + 1'b1;        // wraps 63 -> 0
            cnt_q  <= cnt_q - 1'b1;
            if (CLOAD_GAP != 0) gap_q <= 4'(CLOAD_GAP - 1);
          end
          S_GAP: if (gap_q != 4'd0) gap_q <= gap_q - 1'b1;
          S_CSUM: begin
            if (hs) begin
              if (bin == xor_q) begin
                done_q <= 1'b1;
              end else begin
                err_q      <= 1'b1;
                err_code_q <= ERR_CSUM;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bin_ready = bin_ready_q;
  assign busy      = busy_q;
  assign cload     = cload_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign cin       = cin_q;
  assign caddr     = caddr_q;

endmodule

// File: tb/tb_w4823_coef_loader.sv
// Scoreboard bench for the W4823 coefficient loader.
module tb_w4823_coef_loader;

  localparam int GAP = 2;
  localparam int TMO = 20;

  logic        clk1 = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  bin = 8'h00;
  logic        bin_valid = 1'b0;
  logic        bin_ready;
  logic [16:0] cin;
  logic [5:0]  caddr;
  logic        cload, busy, done, err;
  logic [2:0]  err_code;

  w4823_coef_loader #(.CLOAD_GAP(GAP), .TIMEOUT(TMO), .HDR(8'hA5)) dut (
    .clk1(clk1), .rst_n(rst_n), .bin(bin), .bin_valid(bin_valid),
    .bin_ready(bin_ready), .cin(cin), .caddr(caddr), .cload(cload),
    .busy(busy), .done(done), .err(err), .err_code(err_code)
  );

  always #5 clk1 = ~clk1;

  typedef struct packed {
    logic [5:0]  a;
    logic [16:0] d;
  } wr_t;

  wr_t        exp_q[$];
  int         tot = 0, pass = 0, n_done = 0, n_err = 0;
  logic [7:0] cs_acc = 8'h00;
  wr_t        got;
  wr_t        want;

  // Scoreboard: every cload must match the next expected write.
  always @(negedge clk1) begin
    if (cload) begin
      got = {caddr, cin};
      tot++;
      if (exp_q.size() == 0) begin
        $display("FAIL cload_unexpected: got caddr=%0d cin=%h, none expected", caddr, cin);
      end else begin
        want = exp_q.pop_front();
        if (got !== want)
          $display("FAIL cload_data: got caddr=%0d cin=%h, want caddr=%0d cin=%h",
                   got.a, got.d, want.a, want.d);
        else pass++;
      end
      tot++;
      if (done || err) $display("FAIL cload_overlap: done=%b err=%b with cload", done, err);
      else pass++;
    end
    if (done) n_done++;
    if (err)  n_err++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    @(negedge clk1);
    bin = b;
    bin_valid = 1'b1;
    for (int k = 0; k < 64; k++) begin
      if (bin_ready) begin ok = 1'b1; break; end
      @(negedge clk1);
    end
    tot++;
    if (!ok) begin
      $display("FAIL handshake: byte %h not accepted within 64 cycles", b);
      bin_valid = 1'b0;
    end else begin
      pass++;
      @(posedge clk1);
      #1 bin_valid = 1'b0;
    end
  endtask

  task automatic send_hdr(input logic [7:0] n, input logic [7:0] a0);
    cs_acc = 8'h00;
    send_byte(8'hA5);
    send_byte(n);
    send_byte(a0);
  endtask

  task automatic send_coef(input logic [16:0] c, input logic [5:0] a);
    logic [7:0] b2;
    b2 = {7'd0, c[16]};
    cs_acc = cs_acc ^ c[7:0] ^ c[15:8] ^ b2;
    exp_q.push_back({a, c});
    send_byte(c[7:0]);
    send_byte(c[15:8]);
    send_byte(b2);
    @(negedge clk1);
    tot++;
    if ({cload, bin_ready} !== 2'b10)
      $display("FAIL load_cycle: cload=%b bin_ready=%b, want cload=1 bin_ready=0", cload, bin_ready);
    else pass++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk1);
    tot++;
    if ({bin_ready, cin, caddr, cload, busy, done, err, err_code} !== {1'b1, 17'h0, 6'h0, 4'h0, 3'h0})
      $display("FAIL reset_state: ready=%b cin=%h caddr=%0d cload=%b busy=%b done=%b err=%b code=%0d",
               bin_ready, cin, caddr, cload, busy, done, err, err_code);
    else pass++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk1);
  endtask

  task automatic test_basic;
    int d0, e0;
    d0 = n_done; e0 = n_err;
    send_byte(8'h00);
    send_byte(8'hFF);
    @(negedge clk1);
    tot++;
    if (busy !== 1'b0) $display("FAIL junk_busy: busy=%b, want 0", busy); else pass++;
    send_hdr(8'd3, 8'h3E);
    tot++;
    if (busy !== 1'b1) $display("FAIL frame_busy: busy=%b, want 1", busy); else pass++;
    send_coef(17'h00001, 6'd62);
    send_coef(17'h1FFFF, 6'd63);
    send_coef(17'h0ABCD, 6'd0);
    send_byte(cs_acc);
    @(negedge clk1);
    tot++;
    if ({done, err, busy} !== 3'b100)
      $display("FAIL basic_done: done=%b err=%b busy=%b, want 1 0 0", done, err, busy);
    else pass++;
    @(negedge clk1);
    tot++;
    if (exp_q.size() != 0 || (n_done - d0) != 1 || (n_err - e0) != 0)
      $display("FAIL basic_counts: pending=%0d dones=%0d errs=%0d, want 0 1 0",
               exp_q.size(), n_done - d0, n_err - e0);
    else pass++;
  endtask

  task automatic test_badcnt;
    logic [7:0] ns[2];
    ns[0] = 8'd0; ns[1] = 8'd65;
    for (int i = 0; i < 2; i++) begin
      send_byte(8'hA5);
      send_byte(ns[i]);
      @(negedge clk1);
      tot++;
      if ({err, err_code, bin_ready, busy, cload} !== {1'b1, 3'd1, 1'b1, 1'b0, 1'b0})
        $display("FAIL badcnt_%0d: err=%b code=%0d ready=%b busy=%b cload=%b, want 1 1 1 0 0",
                 ns[i], err, err_code, bin_ready, busy, cload);
      else pass++;
    end
  endtask

  task automatic test_pad;
    send_hdr(8'd2, 8'h05);
    send_coef(17'h12345, 6'd5);
    send_byte(8'h34);
    send_byte(8'h12);
    send_byte(8'h02);
    @(negedge clk1);
    tot++;
    if ({err, err_code, cload, busy} !== {1'b1, 3'd2, 1'b0, 1'b0})
      $display("FAIL pad_err: err=%b code=%0d cload=%b busy=%b, want 1 2 0 0", err, err_code, cload, busy);
    else pass++;
    repeat (4) @(negedge clk1);
    tot++;
    if (exp_q.size() != 0) $display("FAIL pad_pending: %0d writes missing, want 0", exp_q.size());
    else pass++;
  endtask

  task automatic test_badcs;
    send_hdr(8'd2, 8'd10);
    send_coef(17'h00F0F, 6'd10);
    send_coef(17'h10001, 6'd11);
    send_byte(cs_acc ^ 8'h5A);
    @(negedge clk1);
    tot++;
    if ({err, err_code, done} !== {1'b1, 3'd3, 1'b0})
      $display("FAIL badcs: err=%b code=%0d done=%b, want 1 3 0", err, err_code, done);
    else pass++;
    tot++;
    if (exp_q.size() != 0) $display("FAIL badcs_pending: %0d writes missing, want 0", exp_q.size());
    else pass++;
  endtask

  task automatic test_timeout;
    // Stall one short of the budget: frame must survive.
    send_hdr(8'd1, 8'd20);
    cs_acc = 8'h77 ^ 8'h66 ^ 8'h01;
    exp_q.push_back({6'd20, 17'h16677});
    send_byte(8'h77);
    send_byte(8'h66);
    repeat (TMO - 1) @(posedge clk1);
    send_byte(8'h01);
    @(negedge clk1);
    tot++;
    if (cload !== 1'b1) $display("FAIL tmo_survive_load: cload=%b, want 1", cload); else pass++;
    send_byte(cs_acc);
    @(negedge clk1);
    tot++;
    if ({done, err} !== 2'b10) $display("FAIL tmo_survive_done: done=%b err=%b, want 1 0", done, err);
    else pass++;
    // Full budget stall: frame aborts.
    send_hdr(8'd1, 8'd21);
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (TMO) @(negedge clk1);
    tot++;
    if ({err, busy} !== 2'b01) $display("FAIL tmo_early: err=%b busy=%b, want 0 1", err, busy);
    else pass++;
    @(negedge clk1);
    tot++;
    if ({err, err_code, busy} !== {1'b1, 3'd4, 1'b0})
      $display("FAIL tmo_abort: err=%b code=%0d busy=%b, want 1 4 0", err, err_code, busy);
    else pass++;
  endtask

  task automatic test_reset_midframe;
    int d0;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_hdr(8'd3, 8'h10);
    send_coef(17'h0AAAA, 6'd16);
    send_coef(17'h15555, 6'd17);
    repeat (2) @(negedge clk1);
    rst_n = 1'b0;
    #1;
    tot++;
    if ({bin_ready, cin, caddr, cload, busy, done, err, err_code} !== {1'b1, 17'h0, 6'h0, 4'h0, 3'h0})
      $display("FAIL midreset_state: ready=%b cin=%h caddr=%0d cload=%b busy=%b done=%b err=%b code=%0d",
               bin_ready, cin, caddr, cload, busy, done, err, err_code);
    else pass++;
    tot++;
    if (exp_q.size() != 0) $display("FAIL midreset_pending: %0d writes missing, want 0", exp_q.size());
    else pass++;
    repeat (2) @(negedge clk1);
    rst_n = 1'b1;
    d0 = n_done;
    send_hdr(8'd1, 8'h3F);
    send_coef(17'h1C3A5, 6'd63);
    send_byte(cs_acc);
    @(negedge clk1);
    @(negedge clk1);
    tot++;
    if ((n_done - d0) != 1 || exp_q.size() != 0)
      $display("FAIL midreset_fresh: dones=%0d pending=%0d, want 1 0", n_done - d0, exp_q.size());
    else pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_badcnt();
    test_pad();
    test_badcs();
    test_timeout();
    test_reset_midframe();
    repeat (4) @(negedge clk1);
    $display("%0d/%0d checks passed", pass, tot);
    $finish;
  end

endmodule

// File: doc/w4823_coef_loader.md
# w4823_coef_loader

Byte-stream front end for the W4823 FIR coefficient RAM. It parses framed coefficient packets from a host byte interface (UART/SPI bridge) and drives the FIR's `cin`/`caddr`/`cload` write port, one coefficient per pulse. It also checks framing, padding and checksum, and reports status. It sits beside `W4823_FIR` in the FPU top level, on the FIR's slow-clock domain.

## Interface
Parameters:
- `CLOAD_GAP`, default 2: idle cycles forced after each `cload` pulse, range 0–15.
- `TIMEOUT`, default 1024: idle cycles allowed inside a frame before it is aborted.
- `HDR`, default 8'hA5: frame header byte.

Ports:
- `clk1` input, 1 bit: the single clock. All logic is on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `bin` input, 8 bits: host byte.
- `bin_valid` input, 1 bit: `bin` is valid.
- `bin_ready` output, 1 bit: byte is accepted when `bin_valid && bin_ready`.
- `cin` output, 17 bits: coefficient to the FIR.
- `caddr` output, 6 bits: coefficient address.
- `cload` output, 1 bit: one-cycle write strobe.
- `busy` output, 1 bit: high while a frame is in progress.
- `done` output, 1 bit: one-cycle pulse when a frame ends with a good checksum.
- `err` output, 1 bit: one-cycle pulse on abort or bad checksum.
- `err_code` output, 3 bits: cause of the last error. Held until the next `err`.

## Operation
Frame format, in byte order:
- `HDR`
- `N`, the coefficient count, 1..64
- `A0`, the start address (bits 5:0 used, 7:6 ignored)
- N × {b0, b1, b2}, little-endian. Coefficient = {b2[0], b1, b0}. b2[7:1] must be 0.
- `CS`, the XOR of all coefficient bytes.

States: IDLE → CNT → ADR → B0 → B1 → B2 → LOAD → GAP → (B0 | CSUM) → IDLE.
- **IDLE:** `bin_ready`=1. Bytes other than `HDR` are discarded silently. `HDR` moves to CNT.
- **CNT:** N=0 or N>64 gives `err_code`=1 and returns to IDLE. Otherwise N is latched.
- **ADR:** address register ← `A0[5:0]`.
- **B0/B1/B2:** assemble the coefficient and fold each byte into the XOR accumulator. If b2[7:1]≠0: `err_code`=2, abort, no `cload` for that coefficient.
- **LOAD:** `bin_ready`=0. `cin`/`caddr` are driven and `cload`=1 for exactly one cycle. Then the address increments mod 64 (wraps 63→0) and the remaining count decrements.
- **GAP:** `bin_ready`=0 for `CLOAD_GAP` cycles. With `CLOAD_GAP`=0 this state is skipped. Then B0 if count>0, else CSUM.
- **CSUM:** match pulses `done`. Mismatch pulses `err` with `err_code`=3.
- Coefficients are written as they arrive. A bad checksum or abort does not roll back earlier writes; the host must resend.
- **Timeout:** in any state except IDLE/LOAD/GAP, `TIMEOUT` consecutive cycles without a handshake give `err_code`=4, abort, return to IDLE. The counter resets on every accepted byte.
- Abort always returns to IDLE in the next cycle. `busy`=0 in IDLE; otherwise 1.
- `cin` and `caddr` hold their last values between pulses.

## Timing
- Reset values: `bin_ready`=1, `cin`=0, `caddr`=0, `cload`=0, `busy`=0, `done`=0, `err`=0, `err_code`=0, state IDLE.
- All outputs are registered.
- `cload` rises in the cycle after the b2 handshake.
- `bin_ready` is low in LOAD and GAP, so back-to-back coefficients cost 3 + 1 + `CLOAD_GAP` cycles minimum.
- `done`/`err` are asserted the cycle after the CS handshake. They never coincide with `cload`.
- An `HDR` byte arriving mid-frame is treated as data, not resync.
- `rst_n` asserted mid-frame clears everything immediately. A `cload` pulse in progress is dropped.

## Structure
- Package `w4823_pkg`: state enum, `err_code` constants (NONE=0, BADCNT=1, PAD=2, CSUM=3, TMO=4), `COEF_W`=17, `CADDR_W`=6, default `HDR`.
- Sub-module `w4823_byte_tmo`: a loadable down-counter that raises `expired`. Instantiated once.
- Everything else goes in a single FSM plus datapath.

## Test plan
- Frame A5,03,3E, coefs 0x00001/0x1FFFF/0x0ABCD, correct CS → three `cload` pulses at `caddr` 62, 63, 0 with matching `cin`, then `done`, no `err`.
- N=0, and separately N=65 → `err`, `err_code`=1, no `cload`, `bin_ready` high the next cycle.
- Second coefficient with b2=0x02 → first `cload` only, then `err_code`=2 and IDLE.
- Wrong CS byte → all N `cload` pulses occur, then `err_code`=3, no `done`.
- Stall of `TIMEOUT` cycles after b1 → `err_code`=4. A stall of `TIMEOUT`−1 cycles followed by the byte continues normally.
- Junk bytes 00, FF before A5, and `rst_n` pulsed after the second coefficient → junk is ignored. After reset all outputs are at reset values, and a fresh frame loads correctly.
